// File: rtl/word_packer.sv
// word_packer
// Packs ratio narrow beats of in_width bits into one wide word and hands it to
// a downstream depth-1 FIFO. Lane 0 occupies the least significant bits. A
// finished word is held in a pending register until the FIFO can take it. The
// next word may start filling in the same cycle the pending word is enqueued.
//
// Parameters
//   in_width   narrow beat width in bits
//   ratio      beats per output word (1..16)
//
// Ports
//   CLK          clock, rising edge
//   RST          synchronous active-high reset; drops partial and pending words
//   CLR          synchronous clear; same effect as RST on control state.
//                RST takes precedence over CLR.
//   IN_DATA      narrow beat
//   IN_VALID     beat offered
//   IN_LAST      beat closes a (possibly partial) word (LAST_EN builds only)
//   IN_READY     beat accepted when IN_VALID && IN_READY
//   OUT_DATA     packed word, drives downstream FIFO D_IN
//   OUT_MASK     lane-valid mask, bit k covers lane k
//   OUT_ENQ      enqueue command to downstream FIFO
//   OUT_FULL_N   downstream FIFO not full
//
// Build option
//   WORD_PACKER_LAST_EN  when defined, IN_LAST closes partial words and
//                        OUT_MASK reports which lanes were written. When it is
//                        undefined, IN_LAST is ignored and OUT_MASK is all-ones.
module word_packer #(
  parameter int in_width = 8,
  parameter int ratio    = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic [in_width-1:0]       IN_DATA,
  input  logic                      IN_VALID,
  input  logic                      IN_LAST,
  output logic                      IN_READY,
  output logic [in_width*ratio-1:0] OUT_DATA,
  output logic [ratio-1:0]          OUT_MASK,
  output logic                      OUT_ENQ,
  input  logic                      OUT_FULL_N
);

  // The counter is kept at least one bit wide so that ratio=1 still elaborates.
  localparam int            CW       = (ratio > 1) ? $clog2(ratio) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ratio - 1);

  typedef enum logic {FILL = 1'b0, PEND = 1'b1} state_t;

  state_t                    state_q, state_nxt;
  logic [CW-1:0]             cnt_q, cnt_nxt;
  logic [in_width*ratio-1:0] word_q, word_nxt;
  logic                      pending;
  logic                      accept;
  logic                      close_word;
  logic                      last_close;

  // The pending word leaves on the same cycle that the FIFO has room.
  // Therefore a full pipeline accepts one beat per cycle.
  assign pending    = (state_q == PEND);
  assign IN_READY   = !pending || OUT_FULL_N;
  assign OUT_ENQ    = pending && OUT_FULL_N;
  assign accept     = IN_VALID && IN_READY;
  assign close_word = accept && ((cnt_q == CNT_LAST) || last_close);
  assign OUT_DATA   = word_q;

  // Next-state and lane-counter logic. CLR takes precedence over a beat
  // that arrives in the same cycle. A closing beat that is accepted while the
  // old word is enqueued leaves the FSM in PEND with the new word.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (CLR) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end else if (close_word) begin
      state_nxt = PEND;
      cnt_nxt   = '0;
    end else begin
      if (OUT_ENQ) begin
        state_nxt = FILL;
      end
      if (accept) begin
        cnt_nxt = cnt_q + CW'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // The first beat of a word also zeroes the other lanes. As a result, a
  // partial word never carries stale bytes from the previous word.
  always_comb begin
    word_nxt = word_q;
    for (int k = 0; k < ratio; k++) begin
      if (cnt_q == CW'(k)) begin
        word_nxt[k*in_width +: in_width] = IN_DATA;
      end else if (cnt_q == '0) begin
        word_nxt[k*in_width +: in_width] = '0;
      end
    end
  end

  // The data register is not reset. Only the mask and control decide what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && !CLR && accept) begin
      word_q <= word_nxt;
    end
  end

`ifdef WORD_PACKER_LAST_EN
  logic [ratio-1:0] mask_q, mask_nxt;

  assign last_close = IN_LAST;
  assign OUT_MASK   = mask_q;

  // The lane mask follows the data lanes: set the written lane, and clear
  // the other lanes when a new word starts.
  always_comb begin
    mask_nxt = mask_q;
    if (CLR) begin
      mask_nxt = '0;
    end else if (accept) begin
      for (int k = 0; k < ratio; k++) begin
        if (cnt_q == CW'(k)) begin
          mask_nxt[k] = 1'b1;
        end else if (cnt_q == '0) begin
          mask_nxt[k] = 1'b0;
        end
      end
    end
  end

  // Lane mask register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_nxt;
    end
  end
`else
  logic unused_in_last;

  assign unused_in_last = IN_LAST;
  assign last_close     = 1'b0;
  assign OUT_MASK       = '1;
`endif

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer
// Directed bench for word_packer. There are two instances:
//   dut    in_width=8, ratio=4   table of per-cycle vectors plus reset sequences
//   dut_r1 in_width=8, ratio=1   back-to-back single-beat words
// Expectations change with WORD_PACKER_LAST_EN, to match the DUT build.
module tb_word_packer;

  logic        CLK = 1'b0;
  logic        rst, clr;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic        out_enq, out_full_n;

  logic [7:0]  r1_in_data;
  logic        r1_in_valid, r1_in_last, r1_in_ready;
  logic [7:0]  r1_out_data;
  logic [0:0]  r1_out_mask;
  logic        r1_out_enq, r1_out_full_n;

  int tests    = 0;
  int failures = 0;

`ifdef WORD_PACKER_LAST_EN
  localparam logic [3:0] MASK_RST    = 4'h0;
  localparam logic [0:0] R1_MASK_RST = 1'b0;
`else
  localparam logic [3:0] MASK_RST    = 4'hF;
  localparam logic [0:0] R1_MASK_RST = 1'b1;
`endif

  // Clock: 10 time-unit period.
  always #5 CLK = ~CLK;

  word_packer #(.in_width(8), .ratio(4)) dut (
    .CLK(CLK), .RST(rst), .CLR(clr),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_LAST(in_last), .IN_READY(in_ready),
    .OUT_DATA(out_data), .OUT_MASK(out_mask), .OUT_ENQ(out_enq), .OUT_FULL_N(out_full_n)
  );

  word_packer #(.in_width(8), .ratio(1)) dut_r1 (
    .CLK(CLK), .RST(rst), .CLR(clr),
    .IN_DATA(r1_in_data), .IN_VALID(r1_in_valid), .IN_LAST(r1_in_last), .IN_READY(r1_in_ready),
    .OUT_DATA(r1_out_data), .OUT_MASK(r1_out_mask), .OUT_ENQ(r1_out_enq), .OUT_FULL_N(r1_out_full_n)
  );

  // Each record holds the inputs for one cycle and the outputs expected in
  // that cycle, before the next rising edge.
  typedef struct {
    logic        rst, clr, v;
    logic [7:0]  d;
    logic        l, f;
    logic        rdy, enq, chk;
    logic [31:0] data;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic c, input logic v, input logic [7:0] d,
                              input logic l, input logic f, input logic rdy, input logic enq,
                              input logic chk, input logic [31:0] data, input logic [3:0] mask);
    vec_t e;
    e.rst = r; e.clr = c; e.v = v; e.d = d; e.l = l; e.f = f;
    e.rdy = rdy; e.enq = enq; e.chk = chk; e.data = data; e.mask = mask;
    vecs.push_back(e);
  endfunction

  // Drive inputs on the falling edge, then let the combinational outputs settle.
  task automatic apply_stimulus(input logic r, input logic c, input logic v, input logic [7:0] d,
                                input logic l, input logic f);
    @(negedge CLK);
    rst = r; clr = c; in_valid = v; in_data = d; in_last = l; out_full_n = f;
    #1;
  endtask

  // Compare one value and record the result.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the ratio-4 instance and check its outputs.
  task automatic run_vec(input string name, input vec_t e);
    apply_stimulus(e.rst, e.clr, e.v, e.d, e.l, e.f);
    check_output({name, " IN_READY"}, 32'(in_ready), 32'(e.rdy));
    check_output({name, " OUT_ENQ"}, 32'(out_enq), 32'(e.enq));
    if (e.chk) begin
      check_output({name, " OUT_DATA"}, out_data, e.data);
      check_output({name, " OUT_MASK"}, 32'(out_mask), 32'(e.mask));
    end
  endtask

  // Drive one cycle on the ratio-1 instance and check its outputs.
  task automatic r1_step(input string name, input logic v, input logic [7:0] d,
                         input logic enq, input logic chk, input logic [7:0] data);
    @(negedge CLK);
    r1_in_valid = v; r1_in_data = d;
    #1;
    check_output({name, " OUT_ENQ"}, 32'(r1_out_enq), 32'(enq));
    if (chk) begin
      check_output({name, " OUT_DATA"}, 32'(r1_out_data), 32'(data));
      check_output({name, " OUT_MASK"}, 32'(r1_out_mask), 32'h1);
    end
  endtask

  initial begin
    vec_t h;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_full_n = 1'b1;
    r1_in_valid = 1'b0; r1_in_data = '0; r1_in_last = 1'b0; r1_out_full_n = 1'b1;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    #1;
    check_output("reset IN_READY", 32'(in_ready), 32'h1);
    check_output("reset OUT_ENQ", 32'(out_enq), 32'h0);
    check_output("reset OUT_MASK", 32'(out_mask), 32'(MASK_RST));
    check_output("reset r1 IN_READY", 32'(r1_in_ready), 32'h1);
    check_output("reset r1 OUT_ENQ", 32'(r1_out_enq), 32'h0);
    check_output("reset r1 OUT_MASK", 32'(r1_out_mask), 32'(R1_MASK_RST));

    // Four beats sent back to back produce one enqueue on the next cycle.
    add(0,0,1,8'h11,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h22,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h33,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h44,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,0,8'h00,0,1, 1,1,1,32'h44332211,4'hF);
    add(0,0,0,8'h00,0,1, 1,0,0,32'h0,4'h0);
    // Stall for five cycles while a word is pending, then release.
    add(0,0,1,8'h55,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h66,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h77,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h88,0,1, 1,0,0,32'h0,4'h0);
    for (int i = 0; i < 5; i++) add(0,0,1,8'h99,0,0, 0,0,1,32'h88776655,4'hF);
    add(0,0,0,8'h00,0,1, 1,1,1,32'h88776655,4'hF);
    add(0,0,0,8'h00,0,1, 1,0,0,32'h0,4'h0);
    // Two words sent with no gap; the next word is accepted during the enqueue.
    add(0,0,1,8'h01,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h02,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h03,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h04,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h05,0,1, 1,1,1,32'h04030201,4'hF);
    add(0,0,1,8'h06,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h07,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h08,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h09,0,0, 0,0,1,32'h08070605,4'hF);
    add(0,0,1,8'h09,0,1, 1,1,1,32'h08070605,4'hF);
    // CLR discards the leftover beat. CLR again after two beats, with a beat offered in the same cycle.
    add(0,1,0,8'h00,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'hA1,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'hA2,0,1, 1,0,0,32'h0,4'h0);
    add(0,1,1,8'hEE,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h01,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h02,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h03,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h04,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,0,8'h00,0,1, 1,1,1,32'h04030201,4'hF);
    add(0,0,0,8'h00,0,1, 1,0,0,32'h0,4'h0);
`ifdef WORD_PACKER_LAST_EN
    // IN_LAST closes partial words.
    add(0,0,1,8'hAA,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'hBB,1,1, 1,0,0,32'h0,4'h0);
    add(0,0,0,8'h00,0,1, 1,1,1,32'h0000BBAA,4'h3);
    add(0,0,1,8'hCC,1,1, 1,0,0,32'h0,4'h0);
    add(0,0,0,8'h00,0,1, 1,1,1,32'h000000CC,4'h1);
    add(0,0,0,8'h00,0,1, 1,0,0,32'h0,4'h0);
`else
    // IN_LAST is ignored; the word closes only after the fourth beat.
    add(0,0,1,8'h11,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h22,1,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h33,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,1,8'h44,0,1, 1,0,0,32'h0,4'h0);
    add(0,0,0,8'h00,0,1, 1,1,1,32'h44332211,4'hF);
    add(0,0,0,8'h00,0,1, 1,0,0,32'h0,4'h0);
`endif

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // RST after two beats: the partial word is dropped and the next four beats pack from lane 0.
    h = '{rst:0, clr:0, v:1, d:8'h51, l:0, f:1, rdy:1, enq:0, chk:0, data:32'h0, mask:4'h0};
    run_vec("rst_a", h);
    h.d = 8'h52; run_vec("rst_b", h);
    h.rst = 1'b1; h.d = 8'h53; run_vec("rst_c", h);
    h.rst = 1'b0; h.d = 8'h01;
    run_vec("rst_d", h);
    check_output("rst_d OUT_MASK", 32'(out_mask), 32'(MASK_RST));
    h.d = 8'h02; run_vec("rst_e", h);
    h.d = 8'h03; run_vec("rst_f", h);
    h.d = 8'h04; run_vec("rst_g", h);
    h.v = 1'b0; h.d = 8'h00; h.enq = 1'b1; h.chk = 1'b1; h.data = 32'h04030201; h.mask = 4'hF;
    run_vec("rst_h", h);
    h.enq = 1'b0; h.chk = 1'b0; run_vec("rst_i", h);

    // RST while a word is pending and the FIFO is full: no enqueue follows.
    h = '{rst:0, clr:0, v:1, d:8'h61, l:0, f:0, rdy:1, enq:0, chk:0, data:32'h0, mask:4'h0};
    run_vec("prst_a", h);
    h.d = 8'h62; run_vec("prst_b", h);
    h.d = 8'h63; run_vec("prst_c", h);
    h.d = 8'h64; run_vec("prst_d", h);
    h.v = 1'b0; h.d = 8'h00; h.rdy = 1'b0; h.chk = 1'b1; h.data = 32'h64636261; h.mask = 4'hF;
    run_vec("prst_e", h);
    h.rst = 1'b1; h.chk = 1'b0; run_vec("prst_f", h);
    h.rst = 1'b0; h.f = 1'b1; h.rdy = 1'b1; run_vec("prst_g", h);
    run_vec("prst_h", h);

    // ratio=1: every beat is a word, and three enqueues follow in consecutive cycles.
    r1_step("r1_a", 1'b1, 8'd1, 1'b0, 1'b0, 8'd0);
    r1_step("r1_b", 1'b1, 8'd2, 1'b1, 1'b1, 8'd1);
    r1_step("r1_c", 1'b1, 8'd3, 1'b1, 1'b1, 8'd2);
    r1_step("r1_d", 1'b0, 8'd0, 1'b1, 1'b1, 8'd3);
    r1_step("r1_e", 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter in_width, default 8, narrow input beat width in bits.
REQ-002 SHALL have parameter ratio, default 4, input beats per output word; legal range 1..16.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CLR  input  1  synchronous clear; discards partial and pending word.
REQ-006 SHALL have port IN_DATA  input  in_width  narrow beat.
REQ-007 SHALL have port IN_VALID  input  1  beat offered.
REQ-008 SHALL have port IN_LAST  input  1  beat closes a (possibly partial) word.
REQ-009 SHALL have port IN_READY  output  1  beat accepted when IN_VALID && IN_READY.
REQ-010 SHALL have port OUT_DATA  output  in_width*ratio  packed word for the downstream depth-1 FIFO D_IN.
REQ-011 SHALL have port OUT_MASK  output  ratio  lane-valid mask, bit k covers lane k.
REQ-012 SHALL have port OUT_ENQ  output  1  enqueue command to downstream FIFO.
REQ-013 SHALL have port OUT_FULL_N  input  1  downstream FIFO not full.

Function
REQ-014 SHALL hold state: word register, mask register, lane counter cnt (0..ratio-1), pending flag; states FILL (pending=0) and PEND (pending=1).
REQ-015 SHALL drive IN_READY = !pending || OUT_FULL_N, combinationally.
REQ-016 SHALL drive OUT_ENQ = pending && OUT_FULL_N, combinationally; OUT_DATA/OUT_MASK come straight from registers.
REQ-017 SHALL write an accepted beat into lane cnt (lane 0 = bits in_width-1:0) and set mask bit cnt.
REQ-018 SHALL, when accepting a beat at cnt=0, zero all other lanes and mask bits in the same edge.
REQ-019 SHALL, on accepting a beat with cnt=ratio-1 or IN_LAST=1, set pending next cycle and reset cnt to 0; otherwise increment cnt.
REQ-020 SHALL clear pending on any cycle with OUT_ENQ=1 unless the same cycle accepts a word-closing beat, in which case pending stays 1 holding the new word.
REQ-021 SHALL give latency of one cycle from word-closing beat acceptance to OUT_ENQ, given OUT_FULL_N=1.
REQ-022 SHALL sustain one beat per cycle while OUT_FULL_N stays high.
REQ-023 SHALL, in PEND with OUT_FULL_N=0, stall input (IN_READY=0) and hold OUT_DATA/OUT_MASK stable.
REQ-024 SHALL never assert OUT_ENQ when OUT_FULL_N=0.
REQ-025 SHALL treat CLR like RST for control state (cnt=0, pending=0, mask=0), CLR taking priority over a simultaneous beat; RST overrides CLR.

Reset
REQ-026 SHALL on RST=1 at a clock edge set cnt=0, pending=0, mask=0; OUT_ENQ=0 and IN_READY=1 from the next cycle.
REQ-027 SHALL leave the word register data unreset; the value is undefined until written.
REQ-028 SHALL drop any partial or pending word on mid-operation reset; no OUT_ENQ follows.

Configuration
REQ-029 SHALL honour macro WORD_PACKER_LAST_EN: when defined, IN_LAST behaves per REQ-019 and partial words emit with partial OUT_MASK.
REQ-030 SHALL, without WORD_PACKER_LAST_EN, ignore IN_LAST, close words only at cnt=ratio-1, and drive OUT_MASK all-ones.

Verification
REQ-031 SHALL cover: defaults; beats 0x11,0x22,0x33,0x44 back-to-back, OUT_FULL_N=1 -> one cycle later OUT_ENQ=1 for one cycle, OUT_DATA=0x44332211, OUT_MASK=0xF.
REQ-032 SHALL cover: LAST_EN defined; beats 0xAA,0xBB with IN_LAST on 0xBB -> OUT_DATA=0x0000BBAA, OUT_MASK=0x3.
REQ-033 SHALL cover: word pending, OUT_FULL_N=0 for 5 cycles -> IN_READY=0, OUT_ENQ=0, OUT_DATA stable; OUT_FULL_N rises -> OUT_ENQ=1 that cycle.
REQ-034 SHALL cover: ratio=1, continuous beats 1,2,3 with OUT_FULL_N=1 -> OUT_ENQ high 3 consecutive cycles carrying 1,2,3.
REQ-035 SHALL cover: RST and, separately, CLR asserted after 2 of 4 beats -> no OUT_ENQ; next 4 beats 0x01..0x04 -> OUT_DATA=0x04030201.
REQ-036 SHALL cover: LAST_EN undefined, IN_LAST on beat 2 -> ignored, word emits after beat 4 with OUT_MASK=0xF.
